// File: rtl/hazard_ctrl.sv
// hazard_ctrl - pipeline sequencer for the 5-stage core.
//
// Watches for load-use hazards, taken branches/jumps and instruction/data memory
// stalls. From these it drives the PC write enable, the IF_ID hold and flush, the
// ID/EX bubble insert and a global pipeline freeze. When several events occur in
// the same cycle, they are resolved in this fixed order:
// memory hold > load-use stall > branch flush.
//
// Parameters
//   LOAD_STALL_CYCLES  bubbles inserted per load-use hazard (>=1)
//   CNT_W              width of the performance counters
//
// Ports
//   clk_i, rst_i                 clock; synchronous active-high reset
//   id_rs_i, id_rt_i             source register fields of the instruction in ID
//   ex_memread_i, ex_rt_i        load in EX and its destination register
//   branch_taken_i               branch/jump resolved taken in ID
//   imem_stall_i, dmem_stall_i   memory busy flags
//   pc_write_o                   PC update enable
//   ifid_hazard_o                IF_ID keeps its contents
//   ifid_flush_o                 IF_ID loads zeros
//   idex_bubble_o                zero the ID/EX control fields
//   pipe_hold_o                  freeze all pipeline registers
//   state_o                      current FSM state (debug)
//   stall_cnt_o, flush_cnt_o     performance counters
//
// Build option
//   HAZARD_PERF_CNT_EN  When this macro is defined, stall_cnt_o and flush_cnt_o
//                       count the cycles with pc_write_o=0 and with
//                       ifid_flush_o=1, respectively. When it is undefined, both
//                       outputs are tied to zero.
//
// state   | meaning
// S_RUN   | normal issue; detects hazards, branches and memory stalls
// S_STALL | extra load-use bubbles remaining (LOAD_STALL_CYCLES > 1)
// S_HOLD  | pipeline frozen on a memory stall; resumes into ret_state
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             branch_taken_i,
  input  logic             imem_stall_i,
  input  logic             dmem_stall_i,
  output logic             pc_write_o,
  output logic             ifid_hazard_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_hold_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int BW = $clog2(LOAD_STALL_CYCLES + 1);
  localparam logic [BW-1:0] BCNT_INIT = BW'(LOAD_STALL_CYCLES - 1);
  localparam logic [BW-1:0] BCNT_ONE  = BW'(1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t        r_state, w_state_nx;
  state_t        r_ret_state, w_ret_state_nx;
  state_t        w_act_state;
  logic [BW-1:0] r_bcnt, w_bcnt_nx;
  logic          r_flush_pend, w_flush_pend_nx;
  logic          w_load_use;
  logic          w_mem_busy;

  assign w_load_use = ex_memread_i && (ex_rt_i != 5'd0) &&
                      ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
  assign w_mem_busy = imem_stall_i | dmem_stall_i;

  // When a hold releases, the state we froze in is evaluated in the same cycle,
  // so the resume costs no extra cycle.
  always_comb begin
    w_act_state = r_state;
    if (r_state == S_HOLD && !w_mem_busy) begin
      w_act_state = r_ret_state;
    end
  end

  always_comb begin
    pc_write_o      = 1'b0;
    ifid_hazard_o   = 1'b0;
    ifid_flush_o    = 1'b0;
    idex_bubble_o   = 1'b0;
    pipe_hold_o     = 1'b0;
    w_state_nx      = r_state;
    w_ret_state_nx  = r_ret_state;
    w_bcnt_nx       = r_bcnt;
    w_flush_pend_nx = 1'b0;

    case (w_act_state)
      S_HOLD: begin
        pipe_hold_o     = 1'b1;
        w_flush_pend_nx = r_flush_pend | branch_taken_i;
      end

      S_STALL: begin
        if (w_mem_busy) begin
          pipe_hold_o    = 1'b1;
          w_ret_state_nx = S_STALL;
          w_state_nx     = S_HOLD;
        end else begin
          ifid_hazard_o = 1'b1;
          idex_bubble_o = 1'b1;
          w_bcnt_nx     = r_bcnt - BCNT_ONE;
          w_state_nx    = (r_bcnt == BCNT_ONE) ? S_RUN : S_STALL;
        end
      end

      // S_RUN and the unused encoding 3
      default: begin
        w_state_nx = S_RUN;
        if (w_mem_busy) begin
          pipe_hold_o     = 1'b1;
          w_ret_state_nx  = S_RUN;
          w_flush_pend_nx = branch_taken_i;
          w_state_nx      = S_HOLD;
        end else if (r_state == S_HOLD && r_flush_pend) begin
          // A branch taken during the freeze must still redirect fetch.
          pc_write_o   = 1'b1;
          ifid_flush_o = 1'b1;
        end else if (w_load_use) begin
          ifid_hazard_o = 1'b1;
          idex_bubble_o = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            w_bcnt_nx  = BCNT_INIT;
            w_state_nx = S_STALL;
          end
        end else if (branch_taken_i) begin
          pc_write_o   = 1'b1;
          ifid_flush_o = 1'b1;
        end else begin
          pc_write_o = 1'b1;
        end
      end
    endcase

    if (rst_i) begin
      pc_write_o    = 1'b0;
      ifid_hazard_o = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
      pipe_hold_o   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_RUN;
      r_ret_state  <= S_RUN;
      r_bcnt       <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_ret_state  <= w_ret_state_nx;
      r_bcnt       <= w_bcnt_nx;
      r_flush_pend <= w_flush_pend_nx;
    end
  end

  assign state_o = r_state;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_write_o) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (ifid_flush_o) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl. Two instances share the same stimulus:
// u1 uses LOAD_STALL_CYCLES=1 with 32-bit counters, and u3 uses
// LOAD_STALL_CYCLES=3 with 8-bit counters, so counter wrap-around is exercised.
// The driver advances a cycle-level behavioural model and queues the expected
// outputs. The monitor pops the queue on the falling edge and compares.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_memread, br, imem, dmem;

  logic        pcw1, haz1, fl1, bub1, hold1;
  logic [1:0]  st1;
  logic [31:0] sc1, fc1;
  logic        pcw3, haz3, fl3, bub3, hold3;
  logic [1:0]  st3;
  logic [7:0]  sc3, fc3;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) u1 (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .branch_taken_i(br),
    .imem_stall_i(imem), .dmem_stall_i(dmem),
    .pc_write_o(pcw1), .ifid_hazard_o(haz1), .ifid_flush_o(fl1),
    .idex_bubble_o(bub1), .pipe_hold_o(hold1), .state_o(st1),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1));

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(8)) u3 (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .branch_taken_i(br),
    .imem_stall_i(imem), .dmem_stall_i(dmem),
    .pc_write_o(pcw3), .ifid_hazard_o(haz3), .ifid_flush_o(fl3),
    .idex_bubble_o(bub3), .pipe_hold_o(hold3), .state_o(st3),
    .stall_cnt_o(sc3), .flush_cnt_o(fc3));

  typedef struct {
    bit          pcw, haz, fl, bub, hold;
    bit          chk;
    bit [1:0]    st;
    int unsigned scnt, fcnt;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  // Behavioural model state for each instance (index 0 = u1, 1 = u3).
  int          stall_left[2];
  bit          frozen[2];
  bit          pend[2];
  int unsigned m_scnt[2];
  int unsigned m_fcnt[2];

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_step(input int k, input int lsc, input int unsigned mask,
                            output exp_t e);
    bit lu, busy;
    e = '{default: 0};
    lu   = ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
    busy = imem | dmem;
    if (rst) begin
      e.fl = 1; e.bub = 1;
      stall_left[k] = 0; frozen[k] = 0; pend[k] = 0;
      m_scnt[k] = 0; m_fcnt[k] = 0;
      return;
    end
    e.chk  = 1;
    e.st   = frozen[k] ? 2'd2 : (stall_left[k] > 0 ? 2'd1 : 2'd0);
    e.scnt = m_scnt[k];
    e.fcnt = m_fcnt[k];
    if (busy) begin
      e.hold = 1;
      if (!frozen[k]) pend[k] = (stall_left[k] == 0) ? br : 1'b0;
      else            pend[k] = pend[k] | br;
      frozen[k] = 1;
    end else begin
      frozen[k] = 0;
      if (stall_left[k] > 0) begin
        e.haz = 1; e.bub = 1;
        stall_left[k]--;
      end else if (pend[k]) begin
        e.pcw = 1; e.fl = 1;
      end else if (lu) begin
        e.haz = 1; e.bub = 1;
        stall_left[k] = lsc - 1;
      end else if (br) begin
        e.pcw = 1; e.fl = 1;
      end else begin
        e.pcw = 1;
      end
      pend[k] = 0;
    end
    if (!e.pcw) m_scnt[k] = (m_scnt[k] + 1) & mask;
    if (e.fl)   m_fcnt[k] = (m_fcnt[k] + 1) & mask;
`ifndef HAZARD_PERF_CNT_EN
    e.scnt = 0;
    e.fcnt = 0;
`endif
  endtask

  task automatic drive(input bit r, input bit mr, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input bit b, input bit im, input bit dm);
    exp_t e1, e3;
    @(posedge clk);
    #1;
    rst = r; ex_memread = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
    br = b; imem = im; dmem = dm;
    model_step(0, 1, 32'hFFFF_FFFF, e1);
    model_step(1, 3, 32'h0000_00FF, e3);
    q1.push_back(e1);
    q3.push_back(e3);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) drive(r, 0, 5'd3, 5'd1, 5'd2, 0, 0, 0);
  endtask

  task automatic check_dut(input string t, input exp_t e, input bit pcw, input bit haz,
                           input bit fl, input bit bub, input bit hold,
                           input bit [1:0] st, input int unsigned sc,
                           input int unsigned fc);
    cmp({t, ".pc_write"},    pcw,  e.pcw);
    cmp({t, ".ifid_hazard"}, haz,  e.haz);
    cmp({t, ".ifid_flush"},  fl,   e.fl);
    cmp({t, ".idex_bubble"}, bub,  e.bub);
    cmp({t, ".pipe_hold"},   hold, e.hold);
    if (e.chk) begin
      cmp({t, ".state"},     st, e.st);
      cmp({t, ".stall_cnt"}, sc, e.scnt);
      cmp({t, ".flush_cnt"}, fc, e.fcnt);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check_dut("u1", e, pcw1, haz1, fl1, bub1, hold1, st1, sc1, fc1);
    end
    if (q3.size() > 0) begin
      e = q3.pop_front();
      check_dut("u3", e, pcw3, haz3, fl3, bub3, hold3, st3, 32'(sc3), 32'(fc3));
    end
  end

  initial begin
    rst = 1; ex_memread = 0; ex_rt = 3; id_rs = 1; id_rt = 2;
    br = 0; imem = 0; dmem = 0;

    idle(2, 1);                                 // reset
    idle(2, 0);
    drive(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);     // load-use via rs
    idle(4, 0);
    drive(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0);     // ex_rt = 0: no hazard
    idle(2, 0);
    drive(0, 1, 5'd7, 5'd1, 5'd7, 1, 0, 0);     // load-use via rt with branch
    idle(4, 0);
    drive(0, 0, 5'd3, 5'd1, 5'd2, 0, 0, 1);     // dmem 4 cycles, branch in 2nd
    drive(0, 0, 5'd3, 5'd1, 5'd2, 1, 0, 1);
    drive(0, 0, 5'd3, 5'd1, 5'd2, 0, 0, 1);
    drive(0, 0, 5'd3, 5'd1, 5'd2, 0, 0, 1);
    idle(3, 0);
    idle(1, 1);                                 // fresh counters for the next case
    drive(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);     // stall, then dmem during 2nd
    drive(0, 0, 5'd3, 5'd1, 5'd2, 0, 0, 1);
    drive(0, 0, 5'd3, 5'd1, 5'd2, 0, 0, 1);
    drive(0, 0, 5'd3, 5'd1, 5'd2, 0, 0, 1);
    idle(4, 0);
    drive(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);     // reset mid-stall
    idle(1, 1);
    idle(3, 0);
    drive(0, 0, 5'd3, 5'd1, 5'd2, 1, 1, 0);     // reset mid-hold, pending flush
    idle(1, 1);
    idle(3, 0);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 2) == 0,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0);
    end
    idle(2, 0);

    @(negedge clk);
    #1;
    cmp("scoreboard_drain", q1.size() + q3.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
